// File: rtl/irq_controller_pkg.sv
// Shared register map, vector FSM encoding and address-decode helper for the
// multi-source interrupt controller.
package irq_controller_pkg;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_ENABLE  = 2'd1;
  localparam logic [1:0] REG_TRIGGER = 2'd2;
  localparam logic [1:0] REG_ACTIVE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESENT  = 2'd1,
    ST_WAIT_ACK = 2'd2
  } vec_state_t;

  // Window hit: 32-byte block matches the base and the access is 8-byte aligned.
  function automatic logic addr_hit(input logic [63:0] addr, input logic [63:0] base);
    return (addr[63:5] == base[63:5]) && (addr[2:0] == 3'b000);
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// CPU-side bus and interrupt handshake bundle between the CPU (master) and the
// interrupt controller (slave).
interface irq_controller_if #(
  parameter int VEC_W = 4
);
  import irq_controller_pkg::*;

  logic [63:0]      bus_address;
  logic [63:0]      bus_write_data;
  logic             bus_write_enable;
  logic             bus_read_enable;
  logic [63:0]      bus_read_data;
  logic [VEC_W-1:0] interrupt_vector;
  logic             interrupt_ack;

  modport master (
    output bus_address, bus_write_data, bus_write_enable, bus_read_enable, interrupt_ack,
    input  bus_read_data, interrupt_vector
  );

  modport slave (
    input  bus_address, bus_write_data, bus_write_enable, bus_read_enable, interrupt_ack,
    output bus_read_data, interrupt_vector
  );

endinterface

// File: rtl/irq_controller_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module irq_controller_prio_enc #(
  parameter int N_SRC = 4,
  parameter int VEC_W = 4
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [VEC_W-1:0] idx
);

  // Scan from the top down so the last hit (lowest index) is the one kept.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (req[k]) begin
        valid = 1'b1;
        idx   = VEC_W'(k);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Bus-mapped interrupt controller: per-source edge/level latching, masking,
// fixed-priority presentation and edge-qualified acknowledge.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int               N_SRC     = 4,
  parameter int               VEC_W     = 4,
  parameter logic [63:0]      BASE_ADDR = 64'h0000_3000,
  parameter logic [N_SRC-1:0] EDGE_RST  = {N_SRC{1'b1}},
  parameter logic [N_SRC-1:0] EN_RST    = {N_SRC{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] irq_src,
  irq_controller_if.slave  bus
);

  logic [N_SRC-1:0] pending, enable, trigger, src_hist;
  logic [N_SRC-1:0] set_vec, w1c_vec, retire_vec;
  logic [VEC_W-1:0] vector, win_idx;
  logic             win_valid;
  logic             wr_sel, wr_dly, wr_pulse, ack_dly, ack_rise, sel;
  logic [1:0]       reg_idx;
  logic [63:0]      rd_val;
  vec_state_t       state;
  logic             unused_wdata;

  assign unused_wdata = ^bus.bus_write_data[63:N_SRC];

  assign sel      = addr_hit(bus.bus_address, BASE_ADDR);
  assign reg_idx  = bus.bus_address[4:3];
  assign wr_sel   = bus.bus_write_enable && sel;
  assign wr_pulse = wr_sel && !wr_dly;
  assign ack_rise = bus.interrupt_ack && !ack_dly;

  // Edge sources compare against last cycle's sample; level sources pend while high.
  assign set_vec = (trigger & irq_src & ~src_hist) | (~trigger & irq_src);
  assign w1c_vec = (wr_pulse && reg_idx == REG_PENDING) ? bus.bus_write_data[N_SRC-1:0] : '0;

  always_comb begin
    retire_vec = '0;
    for (int k = 0; k < N_SRC; k++)
      retire_vec[k] = (state == ST_PRESENT) && ack_rise && (vector == VEC_W'(k + 1));
  end

  irq_controller_prio_enc #(.N_SRC(N_SRC), .VEC_W(VEC_W)) u_prio_enc (
    .req   (pending & enable),
    .valid (win_valid),
    .idx   (win_idx)
  );

  always_comb begin
    rd_val = '0;
    case (reg_idx)
      REG_PENDING: rd_val[N_SRC-1:0] = pending;
      REG_ENABLE:  rd_val[N_SRC-1:0] = enable;
      REG_TRIGGER: rd_val[N_SRC-1:0] = trigger;
      default:     rd_val[VEC_W-1:0] = vector;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending       <= '0;
      enable        <= EN_RST;
      trigger       <= EDGE_RST;
      src_hist      <= '0;
      wr_dly        <= 1'b0;
      ack_dly       <= 1'b0;
      bus.bus_read_data <= '0;
    end else begin
      src_hist <= irq_src;
      wr_dly   <= wr_sel;
      ack_dly  <= bus.interrupt_ack;
      pending  <= (pending & ~(w1c_vec | retire_vec)) | set_vec;
      if (wr_pulse && reg_idx == REG_ENABLE)  enable  <= bus.bus_write_data[N_SRC-1:0];
      if (wr_pulse && reg_idx == REG_TRIGGER) trigger <= bus.bus_write_data[N_SRC-1:0];
      bus.bus_read_data <= (bus.bus_read_enable && sel) ? rd_val : 64'd0;
    end
  end

  // Vector FSM: once presented, the vector is frozen until an ack edge retires it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      vector <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            state  <= ST_PRESENT;
            vector <= win_idx + VEC_W'(1);
          end
        end
        ST_PRESENT: begin
          if (ack_rise) begin
            state  <= ST_WAIT_ACK;
            vector <= '0;
          end
        end
        default: begin
          vector <= '0;
          if (!bus.interrupt_ack) state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.interrupt_vector = vector;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: reset, edge/level latching, priority,
// ack qualification, bus register access and set/clear collisions.
module tb_irq_controller;

  localparam logic [63:0] A_PEND = 64'h3000;
  localparam logic [63:0] A_EN   = 64'h3008;
  localparam logic [63:0] A_TRIG = 64'h3010;
  localparam logic [63:0] A_ACT  = 64'h3018;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] irq_src;
  int         errors = 0;
  int         checks = 0;
  logic [63:0] rd;

  irq_controller_if #(.VEC_W(4)) bus ();

  irq_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .irq_src (irq_src),
    .bus     (bus)
  );

  always #10 clk = ~clk;

  task automatic bus_write(input logic [63:0] a, input logic [63:0] d, input int n);
    bus.bus_address      = a;
    bus.bus_write_data   = d;
    bus.bus_write_enable = 1'b1;
    repeat (n) @(negedge clk);
    bus.bus_write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [63:0] a, output logic [63:0] d);
    bus.bus_address     = a;
    bus.bus_read_enable = 1'b1;
    @(negedge clk);
    d = bus.bus_read_data;
    bus.bus_read_enable = 1'b0;
  endtask

  // One-cycle ack, then release and give the FSM time to re-present.
  task automatic do_ack();
    bus.interrupt_ack = 1'b1;
    @(negedge clk);
    bus.interrupt_ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    irq_src = '0;
    bus.bus_address = '0;
    bus.bus_write_data = '0;
    bus.bus_write_enable = 1'b0;
    bus.bus_read_enable = 1'b0;
    bus.interrupt_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.interrupt_vector !== 4'd0) begin errors++; $display("FAIL reset_vector: got %0h want 0", bus.interrupt_vector); end
    checks++; if (bus.bus_read_data !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %0h want 0", bus.bus_read_data); end
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(A_EN, rd);
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL reset_enable: got %0h want 0", rd); end
    bus_read(A_TRIG, rd);
    checks++; if (rd !== 64'hF) begin errors++; $display("FAIL reset_trigger: got %0h want f", rd); end
    bus_read(A_PEND, rd);
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL reset_pending: got %0h want 0", rd); end
  endtask

  task automatic test_edge_ack();
    bus_write(A_EN, 64'h4, 1);
    irq_src = 4'b0100;
    @(negedge clk);
    irq_src = 4'b0000;
    checks++; if (bus.interrupt_vector !== 4'd0) begin errors++; $display("FAIL edge_vec_early: got %0h want 0", bus.interrupt_vector); end
    @(negedge clk);
    checks++; if (bus.interrupt_vector !== 4'd3) begin errors++; $display("FAIL edge_vec: got %0h want 3", bus.interrupt_vector); end
    bus_read(A_PEND, rd);
    checks++; if (rd !== 64'h4) begin errors++; $display("FAIL edge_pending: got %0h want 4", rd); end
    // Long ack: the source re-pends mid-ack and must not be retired by the same ack.
    bus.interrupt_ack = 1'b1;
    @(negedge clk);
    checks++; if (bus.interrupt_vector !== 4'd0) begin errors++; $display("FAIL ack_vec_clear: got %0h want 0", bus.interrupt_vector); end
    irq_src = 4'b0100;
    @(negedge clk);
    irq_src = 4'b0000;
    repeat (36) @(negedge clk);
    checks++; if (bus.interrupt_vector !== 4'd0) begin errors++; $display("FAIL ack_hold_vec: got %0h want 0", bus.interrupt_vector); end
    bus_read(A_PEND, rd);
    checks++; if (rd !== 64'h4) begin errors++; $display("FAIL ack_hold_pending: got %0h want 4", rd); end
    bus.interrupt_ack = 1'b0;
    @(negedge clk);
    checks++; if (bus.interrupt_vector !== 4'd0) begin errors++; $display("FAIL ack_release_vec: got %0h want 0", bus.interrupt_vector); end
    @(negedge clk);
    checks++; if (bus.interrupt_vector !== 4'd3) begin errors++; $display("FAIL re_present_vec: got %0h want 3", bus.interrupt_vector); end
    do_ack();
    checks++; if (bus.interrupt_vector !== 4'd0) begin errors++; $display("FAIL edge_final_vec: got %0h want 0", bus.interrupt_vector); end
    bus_read(A_PEND, rd);
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL edge_final_pending: got %0h want 0", rd); end
  endtask

  task automatic test_priority();
    bus_write(A_EN, 64'hF, 1);
    irq_src = 4'b1000;
    @(negedge clk);
    irq_src = 4'b0010;
    @(negedge clk);
    irq_src = 4'b0000;
    checks++; if (bus.interrupt_vector !== 4'd4) begin errors++; $display("FAIL prio_first: got %0h want 4", bus.interrupt_vector); end
    do_ack();
    checks++; if (bus.interrupt_vector !== 4'd2) begin errors++; $display("FAIL prio_second: got %0h want 2", bus.interrupt_vector); end
    irq_src = 4'b0001;
    @(negedge clk);
    irq_src = 4'b0000;
    @(negedge clk);
    checks++; if (bus.interrupt_vector !== 4'd2) begin errors++; $display("FAIL prio_held: got %0h want 2", bus.interrupt_vector); end
    bus_read(A_PEND, rd);
    checks++; if (rd !== 64'h3) begin errors++; $display("FAIL prio_pending: got %0h want 3", rd); end
    bus_read(A_ACT, rd);
    checks++; if (rd !== 64'h2) begin errors++; $display("FAIL active_reg: got %0h want 2", rd); end
    do_ack();
    checks++; if (bus.interrupt_vector !== 4'd1) begin errors++; $display("FAIL prio_third: got %0h want 1", bus.interrupt_vector); end
    do_ack();
    checks++; if (bus.interrupt_vector !== 4'd0) begin errors++; $display("FAIL prio_empty: got %0h want 0", bus.interrupt_vector); end
  endtask

  task automatic test_level();
    bus_write(A_TRIG, 64'hE, 1);
    bus_write(A_EN, 64'h1, 1);
    irq_src = 4'b0001;
    repeat (2) @(negedge clk);
    checks++; if (bus.interrupt_vector !== 4'd1) begin errors++; $display("FAIL level_vec: got %0h want 1", bus.interrupt_vector); end
    bus.interrupt_ack = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.interrupt_vector !== 4'd0) begin errors++; $display("FAIL level_ack_vec: got %0h want 0", bus.interrupt_vector); end
    bus_read(A_PEND, rd);
    checks++; if (rd !== 64'h1) begin errors++; $display("FAIL level_repend: got %0h want 1", rd); end
    bus.interrupt_ack = 1'b0;
    @(negedge clk);
    checks++; if (bus.interrupt_vector !== 4'd0) begin errors++; $display("FAIL level_gap: got %0h want 0", bus.interrupt_vector); end
    @(negedge clk);
    checks++; if (bus.interrupt_vector !== 4'd1) begin errors++; $display("FAIL level_again: got %0h want 1", bus.interrupt_vector); end
    irq_src = 4'b0000;
    do_ack();
    bus_read(A_PEND, rd);
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL level_done: got %0h want 0", rd); end
    bus_write(A_TRIG, 64'hF, 1);
  endtask

  task automatic test_bus();
    bus_write(A_EN, 64'hF, 30);
    bus_read(A_EN, rd);
    checks++; if (rd !== 64'hF) begin errors++; $display("FAIL bus_enable: got %0h want f", rd); end
    bus_write(A_EN, 64'h0, 1);
    irq_src = 4'b0010;
    @(negedge clk);
    irq_src = 4'b0000;
    // Held W1C acts once: a source that re-pends during the hold must survive.
    bus.bus_address      = A_PEND;
    bus.bus_write_data   = 64'h2;
    bus.bus_write_enable = 1'b1;
    repeat (10) @(negedge clk);
    irq_src = 4'b0010;
    @(negedge clk);
    irq_src = 4'b0000;
    repeat (19) @(negedge clk);
    bus.bus_write_enable = 1'b0;
    bus_read(A_PEND, rd);
    checks++; if (rd !== 64'h2) begin errors++; $display("FAIL w1c_once: got %0h want 2", rd); end
    bus_write(A_PEND, 64'h2, 1);
    bus_read(A_PEND, rd);
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL w1c_clear: got %0h want 0", rd); end
    bus_write(A_ACT, 64'hF, 1);
    bus_read(A_ACT, rd);
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL active_ro: got %0h want 0", rd); end
    bus_read(64'h3009, rd);
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL misaligned_read: got %0h want 0", rd); end
    bus.bus_address = A_TRIG;
    @(negedge clk);
    checks++; if (bus.bus_read_data !== 64'h0) begin errors++; $display("FAIL no_read_enable: got %0h want 0", bus.bus_read_data); end
  endtask

  task automatic test_simultaneous();
    bus.bus_address      = A_PEND;
    bus.bus_write_data   = 64'h2;
    bus.bus_write_enable = 1'b1;
    irq_src = 4'b0010;
    @(negedge clk);
    bus.bus_write_enable = 1'b0;
    irq_src = 4'b0000;
    bus_read(A_PEND, rd);
    checks++; if (rd !== 64'h2) begin errors++; $display("FAIL set_wins: got %0h want 2", rd); end
    bus_write(A_EN, 64'h2, 1);
    @(negedge clk);
    checks++; if (bus.interrupt_vector !== 4'd2) begin errors++; $display("FAIL pre_reset_vec: got %0h want 2", bus.interrupt_vector); end
    #5 reset_n = 1'b0;
    #1;
    checks++; if (bus.interrupt_vector !== 4'd0) begin errors++; $display("FAIL async_reset_vec: got %0h want 0", bus.interrupt_vector); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(A_PEND, rd);
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL post_reset_pending: got %0h want 0", rd); end
    bus_read(A_EN, rd);
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL post_reset_enable: got %0h want 0", rd); end
    checks++; if (bus.interrupt_vector !== 4'd0) begin errors++; $display("FAIL post_reset_vec: got %0h want 0", bus.interrupt_vector); end
  endtask

  initial begin
    test_reset();
    test_edge_ack();
    test_priority();
    test_level();
    test_bus();
    test_simultaneous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
